// File: rtl/ddr_dram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ddr_dram_responder
// Description : DRAM-side DDR4 command responder. It decodes MRS/REF/ACT/RD/
//               WR/PRE commands and tracks per-bank open state and MR0. It
//               enforces tMOD, tRFC, tRCD, tRP and burst spacing, returns read
//               bursts after CAS latency, and latches the first protocol
//               violation in a sticky error register.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_dram_responder #(
    parameter int T_MOD     = 24,
    parameter int T_RFC     = 260,
    parameter int T_RCD     = 16,
    parameter int T_RP      = 16,
    parameter int CL        = 17,
    parameter int MRS_WIDTH = 14
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    input  logic [1:0]           bank,
    input  logic [MRS_WIDTH-1:0] addr,
    output logic                 busy,
    output logic                 mrs_done,
    output logic                 ref_done,
    output logic [3:0]           bank_open,
    output logic [MRS_WIDTH-1:0] mr0_q,
    output logic                 rd_valid,
    output logic [15:0]          rd_data,
    output logic                 err,
    output logic [3:0]           err_code
);

    // Wait counter must hold the longer of tMOD / tRFC.
    localparam int c_wait_max = (T_RFC > T_MOD) ? T_RFC : T_MOD;
    localparam int c_wait_w   = $clog2(c_wait_max + 1);
    localparam int c_bank_max = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int c_bank_w   = $clog2(c_bank_max + 1);
    // Read requests travel CL-1 stages before the burst generator picks them up.
    localparam int c_depth    = CL - 1;

    localparam logic [c_wait_w-1:0] c_mod_n = c_wait_w'(T_MOD);
    localparam logic [c_wait_w-1:0] c_rfc_n = c_wait_w'(T_RFC);
    localparam logic [c_bank_w-1:0] c_rcd_n = c_bank_w'(T_RCD);
    localparam logic [c_bank_w-1:0] c_rp_n  = c_bank_w'(T_RP);

    localparam logic [2:0] c_cmd_mrs = 3'd1;
    localparam logic [2:0] c_cmd_ref = 3'd2;
    localparam logic [2:0] c_cmd_act = 3'd3;
    localparam logic [2:0] c_cmd_rd  = 3'd4;
    localparam logic [2:0] c_cmd_wr  = 3'd5;
    localparam logic [2:0] c_cmd_pre = 3'd6;

    localparam logic [3:0] c_err_busy        = 4'd1;
    localparam logic [3:0] c_err_act_open    = 4'd2;
    localparam logic [3:0] c_err_bank_closed = 4'd3;
    localparam logic [3:0] c_err_trcd        = 4'd4;
    localparam logic [3:0] c_err_trp         = 4'd5;
    localparam logic [3:0] c_err_bank_open   = 4'd6;
    localparam logic [3:0] c_err_tccd        = 4'd7;
    localparam logic [3:0] c_err_illegal     = 4'd8;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        MOD_WAIT = 2'd1,
        RFC_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_wait_w-1:0]   r_wait_cnt;

    logic [3:0]            r_bank_open;
    // One counter per bank: while open it counts since ACT, while closed since
    // PRE (or reset), so it serves both the tRCD and the tRP check.
    logic [c_bank_w-1:0]   r_bank_cnt [4];
    logic [3:0]            r_ccd_cnt;
    logic [3:0]            r_ccd_need;
    logic [MRS_WIDTH-1:0]  r_mr0;
    logic                  r_err;
    logic [3:0]            r_err_code;

    logic [c_depth-1:0]    r_pipe_vld;
    logic [c_depth-1:0]    r_pipe_bc4;
    logic [1:0]            r_pipe_bank [c_depth];
    logic [7:0]            r_pipe_col  [c_depth];

    logic [2:0]            r_left;
    logic [1:0]            r_gen_bank;
    logic [7:0]            r_gen_col;
    logic                  r_rd_valid;
    logic [15:0]           r_rd_data;

    logic                  w_cmd_vld;
    logic                  w_accept;
    logic [3:0]            w_code;
    logic                  w_bc4;
    logic                  w_rdwr_acc;
    logic                  w_rd_acc;

    assign w_cmd_vld  = cmd_valid && (cmd != 3'd0);
    assign w_bc4      = (r_mr0[1:0] == 2'b10);
    assign w_rdwr_acc = w_accept && ((cmd == c_cmd_rd) || (cmd == c_cmd_wr));
    assign w_rd_acc   = w_accept && (cmd == c_cmd_rd);

    // Command legality check; each branch tests its rules in priority order.
    always_comb begin
        w_accept = 1'b0;
        w_code   = 4'd0;
        if (w_cmd_vld) begin
            if (r_state != READY) begin
                w_code = c_err_busy;
            end else begin
                case (cmd)
                    c_cmd_mrs, c_cmd_ref: begin
                        if (|r_bank_open) w_code   = c_err_bank_open;
                        else              w_accept = 1'b1;
                    end
                    c_cmd_act: begin
                        if (r_bank_open[bank])              w_code   = c_err_act_open;
                        else if (r_bank_cnt[bank] < c_rp_n) w_code   = c_err_trp;
                        else                                w_accept = 1'b1;
                    end
                    c_cmd_rd, c_cmd_wr: begin
                        if (!r_bank_open[bank])              w_code   = c_err_bank_closed;
                        else if (r_bank_cnt[bank] < c_rcd_n) w_code   = c_err_trcd;
                        else if (r_ccd_cnt < r_ccd_need)     w_code   = c_err_tccd;
                        else                                 w_accept = 1'b1;
                    end
                    c_cmd_pre: w_accept = 1'b1;
                    default:   w_code   = c_err_illegal;
                endcase
            end
        end
    end

    // State register.
    always_ff @(posedge clock_t) begin
        if (reset) r_state <= READY;
        else       r_state <= w_state_nxt;
    end

    // Next-state and wait-phase status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mrs_done    = 1'b0;
        ref_done    = 1'b0;
        case (r_state)
            READY: begin
                if (w_accept && (cmd == c_cmd_mrs))      w_state_nxt = MOD_WAIT;
                else if (w_accept && (cmd == c_cmd_ref)) w_state_nxt = RFC_WAIT;
            end
            MOD_WAIT: begin
                busy = 1'b1;
                if (r_wait_cnt == c_mod_n) begin
                    mrs_done    = 1'b1;
                    w_state_nxt = READY;
                end
            end
            RFC_WAIT: begin
                busy = 1'b1;
                if (r_wait_cnt == c_rfc_n) begin
                    ref_done    = 1'b1;
                    w_state_nxt = READY;
                end
            end
            default: w_state_nxt = READY;
        endcase
    end

    // Wait counter: held at 1 while ready so the first wait cycle reads as 1.
    always_ff @(posedge clock_t) begin
        if (reset)                r_wait_cnt <= c_wait_w'(1);
        else if (r_state == READY) r_wait_cnt <= c_wait_w'(1);
        else                      r_wait_cnt <= r_wait_cnt + 1'b1;
    end

    // Per-bank open flags and saturating ACT/PRE timers.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_bank_open <= 4'b0;
            for (int i = 0; i < 4; i++) r_bank_cnt[i] <= '1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_bank_cnt[i] != '1) r_bank_cnt[i] <= r_bank_cnt[i] + 1'b1;
            end
            if (w_accept && (cmd == c_cmd_act)) begin
                r_bank_open[bank] <= 1'b1;
                r_bank_cnt[bank]  <= c_bank_w'(1);
            end
            if (w_accept && (cmd == c_cmd_pre)) begin
                for (int i = 0; i < 4; i++) begin
                    if (addr[10] || (bank == 2'(i))) begin
                        r_bank_open[i] <= 1'b0;
                        r_bank_cnt[i]  <= c_bank_w'(1);
                    end
                end
            end
        end
    end

    // Column-command spacing: remembers the burst length of the last RD/WR.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_ccd_cnt  <= 4'hF;
            r_ccd_need <= 4'd8;
        end else if (w_rdwr_acc) begin
            r_ccd_cnt  <= 4'd1;
            r_ccd_need <= w_bc4 ? 4'd4 : 4'd8;
        end else if (r_ccd_cnt != 4'hF) begin
            r_ccd_cnt  <= r_ccd_cnt + 4'd1;
        end
    end

    // MR0 shadow and first-violation capture.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_mr0      <= '0;
            r_err      <= 1'b0;
            r_err_code <= 4'd0;
        end else begin
            if (w_accept && (cmd == c_cmd_mrs)) r_mr0 <= addr;
            if (!r_err && (w_code != 4'd0)) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
        end
    end

    // CAS-latency delay line for accepted reads; burst length is frozen here.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_pipe_vld <= '0;
            r_pipe_bc4 <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_pipe_bank[i] <= 2'd0;
                r_pipe_col[i]  <= 8'd0;
            end
        end else begin
            for (int i = c_depth - 1; i > 0; i--) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_bc4[i]  <= r_pipe_bc4[i-1];
                r_pipe_bank[i] <= r_pipe_bank[i-1];
                r_pipe_col[i]  <= r_pipe_col[i-1];
            end
            r_pipe_vld[0]  <= w_rd_acc;
            r_pipe_bc4[0]  <= w_bc4;
            r_pipe_bank[0] <= bank;
            r_pipe_col[0]  <= addr[7:0];
        end
    end

    // Burst generator; a new burst may start on the cycle after the last beat.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 16'd0;
            r_left     <= 3'd0;
            r_gen_bank <= 2'd0;
            r_gen_col  <= 8'd0;
        end else if (r_pipe_vld[c_depth-1]) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= {6'b0, r_pipe_bank[c_depth-1], r_pipe_col[c_depth-1]};
            r_gen_bank <= r_pipe_bank[c_depth-1];
            r_gen_col  <= r_pipe_col[c_depth-1] + 8'd1;
            r_left     <= r_pipe_bc4[c_depth-1] ? 3'd3 : 3'd7;
        end else if (r_left != 3'd0) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= {6'b0, r_gen_bank, r_gen_col};
            r_gen_col  <= r_gen_col + 8'd1;
            r_left     <= r_left - 3'd1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bank_open = r_bank_open;
    assign mr0_q     = r_mr0;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ddr_dram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_dram_responder
// Description : Directed self-checking bench for ddr_dram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_dram_responder;

    localparam logic [2:0] MRS = 3'd1;
    localparam logic [2:0] REF = 3'd2;
    localparam logic [2:0] ACT = 3'd3;
    localparam logic [2:0] RD  = 3'd4;
    localparam logic [2:0] PRE = 3'd6;
    localparam logic [2:0] BAD = 3'd7;

    logic        clock_t = 1'b0;
    logic        reset   = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd  = 3'd0;
    logic [1:0]  bank = 2'd0;
    logic [13:0] addr = 14'd0;
    logic        busy, mrs_done, ref_done, rd_valid, err;
    logic [3:0]  bank_open, err_code;
    logic [13:0] mr0_q;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    ddr_dram_responder dut (
        .clock_t   (clock_t),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .bank      (bank),
        .addr      (addr),
        .busy      (busy),
        .mrs_done  (mrs_done),
        .ref_done  (ref_done),
        .bank_open (bank_open),
        .mr0_q     (mr0_q),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock_t = ~clock_t;

    // Advance to the next cycle; inputs and outputs are handled 1 ns after the edge.
    task automatic tick();
        @(posedge clock_t);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [13:0] a);
        cmd_valid = 1'b1;
        cmd       = c;
        bank      = b;
        addr      = a;
        tick();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        bank      = 2'd0;
        addr      = 14'd0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_bl8 [8] = '{16'h02FE, 16'h02FF, 16'h0200, 16'h0201,
                                 16'h0202, 16'h0203, 16'h0204, 16'h0205};
    logic [15:0] exp_b2b [8] = '{16'h0020, 16'h0021, 16'h0022, 16'h0023,
                                 16'h0040, 16'h0041, 16'h0042, 16'h0043};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then MRS with tMOD timing.
        do_reset();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mrs_done", mrs_done, 0);
        check_eq("rst_ref_done", ref_done, 0);
        check_eq("rst_bank_open", bank_open, 0);
        check_eq("rst_mr0", mr0_q, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_code", err_code, 0);

        issue(MRS, 2'd0, 14'h0002);
        check_eq("mrs_mr0", mr0_q, 14'h0002);
        for (int c = 1; c <= 24; c++) begin
            check_eq("mrs_busy", busy, 1);
            check_eq("mrs_done", mrs_done, (c == 24));
            tick();
        end
        check_eq("mrs_busy_end", busy, 0);
        check_eq("mrs_done_end", mrs_done, 0);
        check_eq("mrs_err", err, 0);

        // REF: ACT in the last tRFC cycle is BUSY, one cycle later accepted.
        do_reset();
        issue(REF, 2'd0, 14'd0);
        for (int c = 1; c < 260; c++) begin
            check_eq("ref_busy", busy, 1);
            check_eq("ref_done_early", ref_done, 0);
            tick();
        end
        check_eq("ref_done", ref_done, 1);
        check_eq("ref_busy_last", busy, 1);
        issue(ACT, 2'd1, 14'd0);
        check_eq("ref_busy_err", err, 1);
        check_eq("ref_busy_code", err_code, 1);
        check_eq("ref_busy_bank", bank_open, 4'b0000);
        check_eq("ref_done_off", ref_done, 0);
        check_eq("ref_ready", busy, 0);
        issue(ACT, 2'd1, 14'd0);
        check_eq("ref_act_ok", bank_open, 4'b0010);

        // BL8 read with column wrap, RD exactly at tRCD.
        do_reset();
        issue(ACT, 2'd2, 14'd0);
        repeat (15) tick();
        issue(RD, 2'd2, 14'h00FE);
        repeat (15) tick();
        check_eq("bl8_pre_valid", rd_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check_eq("bl8_valid", rd_valid, 1);
            check_eq("bl8_data", rd_data, exp_bl8[k]);
            tick();
        end
        check_eq("bl8_post_valid", rd_valid, 0);
        check_eq("bl8_hold", rd_data, 16'h0205);
        check_eq("bl8_err", err, 0);

        // tRCD / tRP boundaries and illegal command.
        do_reset();
        issue(ACT, 2'd1, 14'd0);
        repeat (14) tick();
        issue(RD, 2'd1, 14'd0);
        check_eq("trcd_err", err, 1);
        check_eq("trcd_code", err_code, 4);

        do_reset();
        issue(PRE, 2'd0, 14'd0);
        repeat (14) tick();
        issue(ACT, 2'd0, 14'd0);
        check_eq("trp_code", err_code, 5);
        check_eq("trp_bank", bank_open, 4'b0000);

        do_reset();
        issue(PRE, 2'd0, 14'd0);
        repeat (15) tick();
        issue(ACT, 2'd0, 14'd0);
        check_eq("trp_ok_err", err, 0);
        check_eq("trp_ok_bank", bank_open, 4'b0001);

        do_reset();
        issue(BAD, 2'd0, 14'd0);
        check_eq("illegal_code", err_code, 8);

        // BC4: spacing 3 rejected (single burst), spacing 4 seamless.
        do_reset();
        issue(MRS, 2'd0, 14'h0002);
        repeat (24) tick();
        issue(ACT, 2'd0, 14'd0);
        repeat (15) tick();
        issue(RD, 2'd0, 14'h0010);
        repeat (2) tick();
        issue(RD, 2'd0, 14'h0030);
        check_eq("tccd_err", err, 1);
        check_eq("tccd_code", err_code, 7);
        repeat (12) tick();
        check_eq("bc4_pre_valid", rd_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("bc4_valid", rd_valid, 1);
            check_eq("bc4_data", rd_data, 16'h0010 + 16'(k));
            tick();
        end
        check_eq("bc4_post_valid", rd_valid, 0);
        check_eq("bc4_hold", rd_data, 16'h0013);

        issue(RD, 2'd0, 14'h0020);
        repeat (3) tick();
        issue(RD, 2'd0, 14'h0040);
        check_eq("b2b_code_hold", err_code, 7);
        repeat (11) tick();
        check_eq("b2b_pre_valid", rd_valid, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b_valid", rd_valid, 1);
            check_eq("b2b_data", rd_data, exp_b2b[k]);
            tick();
        end
        check_eq("b2b_post_valid", rd_valid, 0);

        // First-error hold, PRE-all then REF.
        do_reset();
        issue(ACT, 2'd1, 14'd0);
        issue(ACT, 2'd1, 14'd0);
        check_eq("actopen_err", err, 1);
        check_eq("actopen_code", err_code, 2);
        issue(MRS, 2'd0, 14'h0155);
        check_eq("hold_code", err_code, 2);
        check_eq("hold_mr0", mr0_q, 0);
        check_eq("hold_busy", busy, 0);
        issue(PRE, 2'd0, 14'h0400);
        check_eq("preall_bank", bank_open, 4'b0000);
        issue(REF, 2'd0, 14'd0);
        check_eq("ref_after_pre", busy, 1);

        // Reset in the 5th tRFC cycle aborts the wait.
        repeat (4) tick();
        check_eq("rfc5_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_bank", bank_open, 4'b0000);
        check_eq("abort_err", err, 0);
        check_eq("abort_code", err_code, 0);
        issue(MRS, 2'd0, 14'h0123);
        check_eq("abort_mrs_mr0", mr0_q, 14'h0123);
        check_eq("abort_mrs_busy", busy, 1);
        check_eq("abort_mrs_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
